// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD digit constants for the BCD counter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_incrementer.sv
// bcd_incrementer: single-digit BCD +1 with carry; invalid digits collapse to 0 without carry
module bcd_incrementer
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] in,
  input  logic             en,
  output logic [BCD_W-1:0] out,
  output logic             carry
);
  // 9 wraps with carry, anything above 9 is forced to 0 so a ripple stops there
  always_comb begin
    out   = !en ? in : (in >= BCD_MAX) ? '0 : in + 4'd1;
    carry = en && in == BCD_MAX;
  end
endmodule

// File: rtl/bcd_counter_ctrl.sv
// bcd_counter_ctrl: multi-digit BCD counter rippling one shared incrementer LSD first
module bcd_counter_ctrl
  import bcd_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int IDXW   = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_req,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  state_t            state, state_n;
  logic [IDXW-1:0]   idx;
  logic [BCD_W-1:0]  cur, inc_out;
  logic              carry, last, wrap;

  bcd_incrementer u_inc (
    .in    (cur),
    .en    (state == RUN),
    .out   (inc_out),
    .carry (carry)
  );

  // next state: clr aborts from anywhere, load beats inc_req in IDLE, ripple ends on no carry or top digit
  always_comb begin
    cur     = value[idx*BCD_W +: BCD_W];
    last    = idx == IDXW'(DIGITS-1);
    state_n = clr ? IDLE
            : state == IDLE ? ((!load && inc_req) ? RUN : IDLE)
            : state == RUN  ? ((carry && !last) ? RUN : DONE)
            : IDLE;
    wrap    = !clr && state == RUN && carry && last;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // registered outputs, digit index and packed value with per-digit write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      idx      <= '0;
    end else begin
      busy     <= state_n == RUN;
      done     <= state_n == DONE;
      overflow <= wrap;
      idx      <= (state == RUN && state_n == RUN) ? idx + 1'b1 : '0;
      if (clr) value <= '0;
      else if (state == IDLE && load) value <= load_val;
      else if (state == RUN) value[idx*BCD_W +: BCD_W] <= inc_out;
    end
  end
endmodule
